// File: rtl/shift_imm_issue.sv
// shift_imm_issue
// Decodes RV32 SLLI/SRLI/SRAI instructions at accept time and queues the
// decoded operands in a 2-entry skid FIFO that feeds a downstream shift unit.
//
// Parameters:
//   DATA_WIDTH    - width of rs1_data, SrcA and Immediate
//   OPCODE_LENGTH - width of ShiftOp
// Ports:
//   clk       - sole clock, rising edge
//   reset     - asynchronous active-high reset; empties the FIFO
//   in_valid  - instr/rs1_data valid
//   in_ready  - FIFO can accept an entry (count < 2, registered state only)
//   instr     - RV32 instruction word
//   rs1_data  - rs1 register value, becomes SrcA
//   flush     - synchronous discard of all held and same-cycle entries
//   out_valid - head entry valid
//   out_ready - downstream consumes the head entry
//   SrcA, Immediate, ShiftOp, rd_addr, illegal
//             - head entry fields, driven to 0 while out_valid = 0
// Configuration:
//   SHIFT_IMM_ILLEGAL_CHECK_EN - when defined, a shift opcode with a funct7
//   other than 0000000 (SLLI/SRLI) or 0100000 (SRAI) is flagged illegal and
//   decoded as NONE. When undefined, illegal is 0 and only funct3/instr[30]
//   select the operation.
module shift_imm_issue #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    Immediate,
    output logic [OPCODE_LENGTH-1:0] ShiftOp,
    output logic [4:0]               rd_addr,
    output logic                     illegal
);

    localparam logic [OPCODE_LENGTH-1:0] OP_NONE = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLLI = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRLI = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRAI = OPCODE_LENGTH'(4'b1101);

    // FIFO storage, indexed circularly by r_head
    logic [DATA_WIDTH-1:0]    r_srca [2];
    logic [DATA_WIDTH-1:0]    r_imm  [2];
    logic [OPCODE_LENGTH-1:0] r_op   [2];
    logic [4:0]               r_rd   [2];
    logic                     r_ill  [2];
    logic                     r_head;
    logic [1:0]               r_count;

    logic                     w_push;
    logic                     w_pop;
    logic                     w_tail;
    logic                     w_is_shift_opc;
    logic [2:0]               w_funct3;
    logic [6:0]               w_funct7;
    logic [OPCODE_LENGTH-1:0] w_dec_op;
    logic [DATA_WIDTH-1:0]    w_dec_imm;
    logic                     w_dec_ill;
    logic                     w_unused_rs1;

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    // Tail slot is head when empty, the other slot when one entry is held.
    assign w_tail    = r_head ^ (r_count == 2'd1);

    assign w_is_shift_opc = (instr[6:0] == 7'b0010011);
    assign w_funct3       = instr[14:12];
    assign w_funct7       = instr[31:25];
    assign w_unused_rs1   = ^instr[19:15];

    always_comb begin
        w_dec_op  = OP_NONE;
        w_dec_ill = 1'b0;
        if (w_is_shift_opc) begin
`ifdef SHIFT_IMM_ILLEGAL_CHECK_EN
            if (w_funct3 == 3'b001) begin
                if (w_funct7 == 7'b0000000) w_dec_op  = OP_SLLI;
                else                        w_dec_ill = 1'b1;
            end else if (w_funct3 == 3'b101) begin
                if (w_funct7 == 7'b0000000)      w_dec_op  = OP_SRLI;
                else if (w_funct7 == 7'b0100000) w_dec_op  = OP_SRAI;
                else                             w_dec_ill = 1'b1;
            end
`else
            if (w_funct3 == 3'b001)      w_dec_op = OP_SLLI;
            else if (w_funct3 == 3'b101) w_dec_op = instr[30] ? OP_SRAI : OP_SRLI;
`endif
        end
        if (w_dec_op == OP_NONE)
            w_dec_imm = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
        else
            w_dec_imm = {{(DATA_WIDTH-5){1'b0}}, instr[24:20]};
    end

`ifndef SHIFT_IMM_ILLEGAL_CHECK_EN
    logic w_unused_funct7;
    assign w_unused_funct7 = ^w_funct7;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_srca[i] <= '0;
                r_imm[i]  <= '0;
                r_op[i]   <= '0;
                r_rd[i]   <= '0;
                r_ill[i]  <= 1'b0;
            end
        end else if (flush) begin
            // Stale slot contents are harmless: outputs are gated by out_valid.
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_srca[w_tail] <= rs1_data;
                r_imm[w_tail]  <= w_dec_imm;
                r_op[w_tail]   <= w_dec_op;
                r_rd[w_tail]   <= instr[11:7];
                r_ill[w_tail]  <= w_dec_ill;
            end
            if (w_pop)
                r_head <= ~r_head;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign SrcA      = out_valid ? r_srca[r_head] : '0;
    assign Immediate = out_valid ? r_imm[r_head]  : '0;
    assign ShiftOp   = out_valid ? r_op[r_head]   : '0;
    assign rd_addr   = out_valid ? r_rd[r_head]   : '0;
    assign illegal   = out_valid ? r_ill[r_head]  : 1'b0;

endmodule

// File: tb/tb_shift_imm_issue.sv
// Directed testbench for shift_imm_issue. Inputs are driven on the falling
// edge and outputs sampled on the falling edge, half a cycle from the
// accepting rising edge.
module tb_shift_imm_issue;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] SrcA;
    logic [31:0] Immediate;
    logic [3:0]  ShiftOp;
    logic [4:0]  rd_addr;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] I_SRAI = 32'h40235293;
    localparam logic [31:0] I_SRLI = 32'h00235293;
    localparam logic [31:0] I_SLLI = 32'h00231293;
    localparam logic [31:0] I_ADDI = 32'hFF830293;
    localparam logic [31:0] I_BAD  = 32'h02235293;

    shift_imm_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_data(rs1_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .SrcA(SrcA),
        .Immediate(Immediate), .ShiftOp(ShiftOp), .rd_addr(rd_addr),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rs1);
        in_valid = v;
        instr    = ins;
        rs1_data = rs1;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #2;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (SrcA !== 32'h0 || Immediate !== 32'h0 || ShiftOp !== 4'h0 || rd_addr !== 5'h0 || illegal !== 1'b0) begin
            failures++; $display("FAIL reset_data got=%h/%h/%h/%h/%b exp=0", SrcA, Immediate, ShiftOp, rd_addr, illegal); end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_srai;
        out_ready = 1'b1;
        drive(1'b1, I_SRAI, 32'hFFFFFFF8);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL srai_valid got=%b exp=1", out_valid); end
        checks++; if (SrcA !== 32'hFFFFFFF8) begin failures++; $display("FAIL srai_srca got=%h exp=fffffff8", SrcA); end
        checks++; if (Immediate !== 32'h2) begin failures++; $display("FAIL srai_imm got=%h exp=00000002", Immediate); end
        checks++; if (ShiftOp !== 4'b1101) begin failures++; $display("FAIL srai_op got=%b exp=1101", ShiftOp); end
        checks++; if (rd_addr !== 5'd5 || illegal !== 1'b0) begin failures++; $display("FAIL srai_rd_ill got=%0d/%b exp=5/0", rd_addr, illegal); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || SrcA !== 32'h0 || Immediate !== 32'h0 || ShiftOp !== 4'h0) begin
            failures++; $display("FAIL srai_drained got=%b/%h/%h/%b exp=0/0/0/0", out_valid, SrcA, Immediate, ShiftOp); end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        drive(1'b1, I_SRLI, 32'h10);
        @(negedge clk);
        drive(1'b1, I_SLLI, 32'h10);
        checks++; if (out_valid !== 1'b1 || ShiftOp !== 4'b0101 || Immediate !== 32'h2 || SrcA !== 32'h10) begin
            failures++; $display("FAIL b2b_first got=%b/%b/%h/%h exp=1/0101/2/10", out_valid, ShiftOp, Immediate, SrcA); end
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        checks++; if (out_valid !== 1'b1 || ShiftOp !== 4'b0001 || Immediate !== 32'h2 || SrcA !== 32'h10) begin
            failures++; $display("FAIL b2b_second got=%b/%b/%h/%h exp=1/0001/2/10", out_valid, ShiftOp, Immediate, SrcA); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_addi;
        out_ready = 1'b1;
        drive(1'b1, I_ADDI, 32'h7);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        checks++; if (out_valid !== 1'b1 || ShiftOp !== 4'b0000 || illegal !== 1'b0) begin
            failures++; $display("FAIL addi_op got=%b/%b/%b exp=1/0000/0", out_valid, ShiftOp, illegal); end
        checks++; if (Immediate !== 32'hFFFFFFF8 || rd_addr !== 5'd5) begin
            failures++; $display("FAIL addi_imm got=%h/%0d exp=fffffff8/5", Immediate, rd_addr); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive(1'b1, I_SRAI, 32'h1);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_one got=%b exp=1", in_ready); end
        drive(1'b1, I_SRLI, 32'h2);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%b exp=0", in_ready); end
        checks++; if (SrcA !== 32'h1 || ShiftOp !== 4'b1101) begin failures++; $display("FAIL bp_head got=%h/%b exp=1/1101", SrcA, ShiftOp); end
        drive(1'b1, I_SLLI, 32'h3);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        checks++; if (in_ready !== 1'b0 || SrcA !== 32'h1 || ShiftOp !== 4'b1101 || out_valid !== 1'b1) begin
            failures++; $display("FAIL bp_stable got=%b/%h/%b/%b exp=0/1/1101/1", in_ready, SrcA, ShiftOp, out_valid); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || SrcA !== 32'h2 || ShiftOp !== 4'b0101 || in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_second got=%b/%h/%b/%b exp=1/2/0101/1", out_valid, SrcA, ShiftOp, in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_drained got=%b/%b exp=0/1", out_valid, in_ready); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        drive(1'b1, I_SRAI, 32'h11);
        @(negedge clk);
        drive(1'b1, I_SLLI, 32'h22);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_prefull got=%b exp=0", in_ready); end
        flush = 1'b1; out_ready = 1'b1;
        drive(1'b1, I_ADDI, 32'h33);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || SrcA !== 32'h0) begin
            failures++; $display("FAIL flush_empty got=%b/%b/%h exp=0/1/0", out_valid, in_ready, SrcA); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_emit got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid_stall;
        out_ready = 1'b0;
        drive(1'b1, I_SRLI, 32'h44);
        @(negedge clk);
        drive(1'b1, I_SLLI, 32'h55);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || SrcA !== 32'h0 || ShiftOp !== 4'h0) begin
            failures++; $display("FAIL rst_async got=%b/%b/%h/%b exp=0/1/0/0", out_valid, in_ready, SrcA, ShiftOp); end
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b1;
        drive(1'b1, I_SRAI, 32'h66);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        checks++; if (out_valid !== 1'b1 || SrcA !== 32'h66 || ShiftOp !== 4'b1101) begin
            failures++; $display("FAIL rst_first_accept got=%b/%h/%b exp=1/66/1101", out_valid, SrcA, ShiftOp); end
        @(negedge clk);
    endtask

    task automatic test_illegal;
        logic [3:0]  exp_op;
        logic        exp_ill;
        logic [31:0] exp_imm;
`ifdef SHIFT_IMM_ILLEGAL_CHECK_EN
        exp_op = 4'b0000; exp_ill = 1'b1; exp_imm = 32'h00000022;
`else
        exp_op = 4'b0101; exp_ill = 1'b0; exp_imm = 32'h00000002;
`endif
        out_ready = 1'b1;
        drive(1'b1, I_BAD, 32'h9);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        checks++; if (out_valid !== 1'b1 || illegal !== exp_ill || ShiftOp !== exp_op) begin
            failures++; $display("FAIL illegal_flag got=%b/%b/%b exp=1/%b/%b", out_valid, illegal, ShiftOp, exp_ill, exp_op); end
        checks++; if (Immediate !== exp_imm) begin failures++; $display("FAIL illegal_imm got=%h exp=%h", Immediate, exp_imm); end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_srai;
        test_back_to_back;
        test_addi;
        test_backpressure;
        test_flush;
        test_reset_mid_stall;
        test_illegal;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_imm_issue.md
SHIFT_IMM_ISSUE -- requirements
Module: shift_imm_issue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width of SrcA and Immediate.
REQ-002 SHALL have parameter OPCODE_LENGTH, default 4, width of ShiftOp.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  instr/rs1_data valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an entry.
REQ-007 SHALL have port instr  input  32  RV32 instruction word.
REQ-008 SHALL have port rs1_data  input  DATA_WIDTH  rs1 register value.
REQ-009 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-010 SHALL have port out_valid  output  1  SrcA/Immediate/ShiftOp/rd_addr/illegal valid.
REQ-011 SHALL have port out_ready  input  1  downstream shift unit consumes entry.
REQ-012 SHALL have port SrcA  output  DATA_WIDTH  operand for the shift unit.
REQ-013 SHALL have port Immediate  output  DATA_WIDTH  decoded immediate.
REQ-014 SHALL have port ShiftOp  output  OPCODE_LENGTH  operation select.
REQ-015 SHALL have port rd_addr  output  5  destination register, instr[11:7].
REQ-016 SHALL have port illegal  output  1  malformed shift encoding flag.

Function
REQ-017 SHALL accept an entry when in_valid && in_ready on a rising clk edge; ignore instr/rs1_data otherwise.
REQ-018 SHALL decode at accept: opcode 0010011 with funct3 001 -> SLLI (4'b0001); funct3 101, instr[30]=0 -> SRLI (4'b0101); funct3 101, instr[30]=1 -> SRAI (4'b1101); any other instr -> NONE (4'b0000).
REQ-019 SHALL set Immediate for SLLI/SRLI/SRAI to zero-extended shamt {27'b0, instr[24:20]}; for NONE to sign-extended instr[31:20].
REQ-020 SHALL set SrcA = rs1_data captured at accept.
REQ-021 SHALL hold entries in a 2-entry FIFO (skid buffer), count 0..2, in_ready = (count < 2) from registered state only.
REQ-022 SHALL present an entry with out_valid=1 the cycle after its accept (latency 1) when the FIFO was empty.
REQ-023 SHALL pop head on out_valid && out_ready; SHALL keep all outputs stable while out_valid && !out_ready.
REQ-024 SHALL, on simultaneous push and pop at count 1, keep count 1 with the new entry at head next cycle.
REQ-025 SHALL preserve program order: outputs emerge in accept order, none dropped or duplicated.
REQ-026 SHALL, when flush=1, set count to 0 next cycle, discard any same-cycle accept and pop; out_valid=0 next cycle; in_ready=1 next cycle.
REQ-027 SHALL drive SrcA, Immediate, ShiftOp, rd_addr, illegal to 0 whenever out_valid=0.

Reset
REQ-028 SHALL, on reset assertion, immediately clear count, out_valid=0, in_ready=1 after reset, all data outputs 0, irrespective of clk.
REQ-029 SHALL, on reset mid-transfer, discard all held entries; first accept allowed on first rising clk with reset low.

Configuration
REQ-030 SHALL support macro SHIFT_IMM_ILLEGAL_CHECK_EN.
REQ-031 SHALL, with the macro defined, flag a shift-opcode instr as illegal=1 and ShiftOp=NONE when funct7 is not 0000000 (SLLI/SRLI) or 0100000 (SRAI), including instr[25]=1.
REQ-032 SHALL, without the macro, tie illegal to 0 and decode from funct3 and instr[30] only, ignoring other funct7 bits.

Verification
REQ-033 SRAI x5,x6,2 (0x40235293), rs1_data 0xFFFFFFF8, out_ready=1 -> next cycle out_valid=1, SrcA 0xFFFFFFF8, Immediate 0x00000002, ShiftOp 1101, rd_addr 5.
REQ-034 SRLI 0x00235293 then SLLI 0x00231293 back-to-back, rs1_data 0x10 -> ShiftOp 0101 then 0001, both Immediate 0x2, order preserved.
REQ-035 ADDI 0xFF830293 -> ShiftOp 0000, Immediate 0xFFFFFFF8, illegal 0.
REQ-036 out_ready=0, three accepts attempted -> two accepted, in_ready=0 after second, head stable; out_ready=1 -> both drain in order, in_ready=1.
REQ-037 count 2, flush=1 with in_valid=1 -> next cycle out_valid=0, count 0, new instr not emitted; async reset mid-stall -> same empty state.
REQ-038 0x02235293: with SHIFT_IMM_ILLEGAL_CHECK_EN -> illegal 1, ShiftOp 0000; without -> illegal 0, ShiftOp 0101.
